// File: rtl/contador_modulo_n_pkg.sv
// Shared encodings for the alarm-system timers: end-of-count mode and count direction.
// Other timers import these so that every control FSM drives them the same way.
package contador_modulo_n_pkg;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : contador_modulo_n_pkg

// File: rtl/prescaler_enable.sv
// Clock-enable divider: emits a one-cycle tick on every PRESCALE-th enabled cycle.
// Also used to derive LED blink rates.
module prescaler_enable #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int             PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p;

    // With PRESCALE = 1, P_LAST is 0 and p never leaves 0, so tick degenerates to en.
    assign tick = en && (p == P_LAST);

    // NOTE: non-blocking assignments so every flop samples pre-edge values, regardless of block order.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            p <= '0;
        end else if (restart) begin
            p <= '0;
        end else if (tick) begin
            p <= '0;
        end else if (en) begin
            p <= p + PW'(1);
        end
    end

endmodule : prescaler_enable

// File: rtl/contador_modulo_n.sv
// Parametrised modulo-N up/down counter with prescaler, sync load/clear, wrap or one-shot
// end-of-count, and a terminal-count pulse for cascading.
module contador_modulo_n
    import contador_modulo_n_pkg::*;
#(
    parameter int MODULO   = 5,
    parameter int WIDTH    = (MODULO > 2) ? $clog2(MODULO) : 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down,
    input  logic             mode,
    output logic [WIDTH-1:0] s,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    logic             tick;
    logic             restart;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] load_clamped;

    // Any synchronous clear or load realigns the prescaler phase.
    assign restart = sclr | load;

    prescaler_enable #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .clear   (clear),
        .en      (en),
        .restart (restart),
        .tick    (tick)
    );

    assign load_clamped = (load_val <= MAX_VAL) ? load_val : MAX_VAL;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        next_s   = s;
        terminal = '0;
        if (up_down == DIR_UP) begin
            terminal = MAX_VAL;
            next_s   = (s == MAX_VAL) ? '0 : s + WIDTH'(1);
        end else begin
            terminal = '0;
            next_s   = (s == '0) ? MAX_VAL : s - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            s    <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (sclr) begin
                s    <= '0;
                done <= 1'b0;
            end else if (load) begin
                s    <= load_clamped;
                done <= 1'b0;
            end else if (tick && !done) begin
                s <= next_s;
                if (mode == MODE_WRAP) begin
                    tc <= (s == terminal);
                end else if (next_s == terminal) begin
                    tc   <= 1'b1;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule : contador_modulo_n
